tbb_mix_pdm: RTL

TBB_MIX_PDM -- requirements
Module: tbb_mix_pdm

---
 rtl/tbb_mix_pkg.sv | 25 ++
 rtl/tbb_sd_mod.sv | 53 +++++
 rtl/tbb_mix_pdm.sv | 105 ++++++++++
 3 files changed

// File: rtl/tbb_mix_pkg.sv
// tbb_mix_pkg: shared sizes and register layout for the tone mixer / PDM block.
//   NUM_CH      number of 1-bit tone channels
//   VOL_W       width of a channel volume register
//   SUM_W       width of the weighted channel sum
//   FULL_SCALE  largest possible sum (NUM_CH * max volume), also the modulator modulus
//   SEL_LSB/SEL_W, MUTE_BIT  field positions inside a control-register write
package tbb_mix_pkg;

  localparam int unsigned NUM_CH     = 6;
  localparam int unsigned VOL_W      = 4;
  localparam int unsigned SUM_W      = 7;
  localparam int unsigned FULL_SCALE = 90;

  // Control register layout on the nibble bus
  localparam int unsigned SEL_LSB  = 0;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned MUTE_BIT = 3;

  // Register address decoded from A0
  typedef enum logic {
    ADDR_CTRL = 1'b0,
    ADDR_VOL  = 1'b1
  } addr_e;

endpackage

// File: rtl/tbb_sd_mod.sv
// tbb_sd_mod: first-order sigma-delta modulator.
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset
//   MUTE  forces PDM low and parks the accumulator at zero
//   MIX   level to modulate, 0..FULL_SCALE
//   PDM   registered bitstream; density = MIX / FULL_SCALE
module tbb_sd_mod
  import tbb_mix_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             MUTE,
  input  logic [SUM_W-1:0] MIX,
  output logic             PDM
);

  logic [SUM_W-1:0] acc_r;
  logic             pdm_r;
  logic [SUM_W:0]   t_s;        // one bit wider: acc (<90) + MIX (<=90) can reach 179
  logic [SUM_W-1:0] acc_nxt_s;
  logic             pdm_nxt_s;

  // Next accumulator / output bit: wrap modulo FULL_SCALE, emit 1 on each wrap
  always_comb begin
    t_s       = {1'b0, acc_r} + {1'b0, MIX};
    acc_nxt_s = acc_r;
    pdm_nxt_s = 1'b0;
    if (MUTE) begin
      acc_nxt_s = '0;
      pdm_nxt_s = 1'b0;
    end else if (t_s >= (SUM_W+1)'(FULL_SCALE)) begin
      acc_nxt_s = SUM_W'(t_s - (SUM_W+1)'(FULL_SCALE));
      pdm_nxt_s = 1'b1;
    end else begin
      acc_nxt_s = t_s[SUM_W-1:0];
      pdm_nxt_s = 1'b0;
    end
  end

  // Modulator state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r <= '0;
      pdm_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      pdm_r <= pdm_nxt_s;
    end
  end

  assign PDM = pdm_r;

endmodule

// File: rtl/tbb_mix_pdm.sv
// tbb_mix_pdm: weighted mixer of six 1-bit tone channels feeding a PDM output.
//   CLK     system clock, rising edge
//   RST     synchronous active-high reset
//   FCLK    one-cycle sample strobe; loads MIX with the weighted channel sum
//   S       tone channel bits
//   D       nibble data bus for register writes
//   A0      register address: 0 = control (SEL, MUTE), 1 = volume of channel SEL
//   WR      write level; a write happens only on its rising edge
//   PDM     sigma-delta bitstream
//   MIX     registered weighted sum, 0..90
//   MUTE_O  current mute state
module tbb_mix_pdm
  import tbb_mix_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              FCLK,
  input  logic [NUM_CH-1:0] S,
  input  logic [VOL_W-1:0]  D,
  input  logic              A0,
  input  logic              WR,
  output logic              PDM,
  output logic [SUM_W-1:0]  MIX,
  output logic              MUTE_O
);

  logic              wr_q_r;
  logic              wr_edge_s;
  logic [SEL_W-1:0]  sel_r;
  logic              mute_r;
  logic [VOL_W-1:0]  vol_r [NUM_CH];
  logic [SUM_W-1:0]  mix_r;
  logic [SUM_W-1:0]  sum_s;

  // wr_q resets to 1 so a WR level held through reset release is not a write
  assign wr_edge_s = WR & ~wr_q_r;

  // Weighted sum of active channels; max 6*15 = 90 fits SUM_W without overflow
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (S[i]) begin
        sum_s = sum_s + SUM_W'(vol_r[i]);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  // Write strobe history for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q_r <= 1'b1;
    end else begin
      wr_q_r <= WR;
    end
  end

  // Control register: channel select and mute
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_r  <= '0;
      mute_r <= 1'b0;
    end else if (wr_edge_s && (addr_e'(A0) == ADDR_CTRL)) begin
      sel_r  <= D[SEL_LSB +: SEL_W];
      mute_r <= D[MUTE_BIT];
    end
  end

  // Volume registers; a SEL of 6 or 7 matches no channel so the write is dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        vol_r[i] <= '0;
      end
    end else if (wr_edge_s && (addr_e'(A0) == ADDR_VOL)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_r == SEL_W'(i)) begin
          vol_r[i] <= D;
        end
      end
    end
  end

  // Sample register; uses the pre-write volumes when a write coincides with FCLK
  always_ff @(posedge CLK) begin
    if (RST) begin
      mix_r <= '0;
    end else if (FCLK) begin
      mix_r <= sum_s;
    end
  end

  tbb_sd_mod u_sd_mod (
    .CLK  (CLK),
    .RST  (RST),
    .MUTE (mute_r),
    .MIX  (mix_r),
    .PDM  (PDM)
  );

  assign MIX    = mix_r;
  assign MUTE_O = mute_r;

endmodule
